// File: rtl/rr_mux_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_pkg
//  Purpose  : Shared types for the round-robin mux arbiter.
//             IDLE: no owner, arbitration runs this cycle.
//             LOCK: one requester owns the shared output until its last beat.
//  Revision : 1.0  initial release
// ============================================================================
package rr_mux_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

endpackage : rr_mux_pkg
`default_nettype wire

// File: rtl/rr_mux_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational rotated priority encoder. Returns the first
//             asserted request found scanning ptr, ptr+1, ... N-1, 0, ...
//             ptr-1. Works for any N >= 2, power of two or not.
//  Ports    : req    in  N   request vector
//             ptr    in  SW  index with highest priority (must be < N)
//             winner out SW  index of the selected requester (0 if none)
//             any    out 1   at least one request is asserted
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] winner,
  output logic          any
);

  // One extra bit so ptr + k (max 2N-2) never overflows before the wrap.
  logic [SW:0] idx;

  always_comb begin
    winner = '0;
    any    = |req;
    idx    = '0;
    // Scan from lowest to highest priority so the last hit written is the
    // highest-priority one.
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SW + 1)'(k);
      if (idx >= (SW + 1)'(N)) begin
        idx = idx - (SW + 1)'(N);
      end
      if (req[idx[SW-1:0]]) begin
        winner = idx[SW-1:0];
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_mux_arbiter
//  Purpose  : Round-robin arbiter owning the select of a shared N:1 beat mux.
//             A grant is held for a whole packet (until the owner's last beat
//             transfers), then priority rotates to the next index. Each packet
//             is followed by one idle arbitration cycle.
//  Ports    : clk      in   1    clock, rising edge
//             rst_n    in   1    synchronous reset, active-low
//             req      in   N    per-requester beat valid
//             data     in   N*W  beat i at data[i*W +: W]
//             last     in   N    per-requester end-of-packet flag
//             gnt      out  N    one-hot beat-accepted strobe
//             o_valid  out  1    shared output valid
//             o_data   out  W    shared output beat
//             o_ready  in   1    downstream ready
//             sel      out  SW   current owner index
//             busy     out  1    packet lock held
//  Revision : 1.0  initial release
// ============================================================================
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data,
  input  logic [N-1:0]    last,
  output logic [N-1:0]    gnt,
  output logic            o_valid,
  output logic [W-1:0]    o_data,
  input  logic            o_ready,
  output logic [SW-1:0]   sel,
  output logic            busy
);

  state_e        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel_q, sel_d;

  logic [SW-1:0] pick_winner;
  logic          pick_any;
  logic [W-1:0]  beat [N];
  logic          xfer;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_winner),
    .any    (pick_any)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      beat[i] = data[i*W +: W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_winner;
          state_d = LOCK;
        end
      end
      LOCK: begin
        // sel keeps the finished owner; only the priority pointer moves.
        if (xfer && last[sel_q]) begin
          state_d = IDLE;
          ptr_d   = (sel_q == SW'(N - 1)) ? '0 : sel_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Gated by rst_n so no grant leaks out during a reset cycle
  // that interrupts a packet.
  always_comb begin
    gnt     = '0;
    o_valid = 1'b0;
    o_data  = '0;
    if (state_q == LOCK && rst_n) begin
      o_valid    = req[sel_q];
      gnt[sel_q] = req[sel_q] & o_ready;
      if (req[sel_q]) begin
        o_data = beat[sel_q];
      end
    end
  end

  assign xfer = |gnt;
  assign sel  = sel_q;
  assign busy = (state_q == LOCK);

endmodule : rr_mux_arbiter
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_mux_arbiter
//  Purpose  : Directed, table-driven bench for rr_mux_arbiter (N=4) plus a
//             short hand-written sequence on an N=3 instance for wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rr_mux_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic        rst_n;
  logic [3:0]  req, last, gnt;
  logic [31:0] data;
  logic        o_valid, o_ready, busy;
  logic [7:0]  o_data;
  logic [1:0]  sel;

  rr_mux_arbiter #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .last(last),
    .gnt(gnt), .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
    .sel(sel), .busy(busy)
  );

  // N=3 instance
  logic        rst3_n;
  logic [2:0]  req3, last3, gnt3;
  logic [23:0] data3;
  logic        o_valid3, o_ready3, busy3;
  logic [7:0]  o_data3;
  logic [1:0]  sel3;

  rr_mux_arbiter #(.N(3), .W(8)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req(req3), .data(data3), .last(last3),
    .gnt(gnt3), .o_valid(o_valid3), .o_data(o_data3), .o_ready(o_ready3),
    .sel(sel3), .busy(busy3)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       rdy;
    logic       chk;
    logic [3:0] gnt;
    logic       vld;
    logic [7:0] dat;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] rq,
                              input logic [3:0] l, input logic rd,
                              input logic c, input logic [3:0] g,
                              input logic v, input logic [7:0] d,
                              input logic [1:0] s, input logic b);
    vec_t t;
    t.rst_n = r; t.req = rq; t.last = l; t.rdy = rd; t.chk = c;
    t.gnt = g; t.vld = v; t.dat = d; t.sel = s; t.busy = b;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //              rst  req    last   rdy  chk   gnt   vld  dat     sel   busy
    // reset
    vecs[0]  = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    vecs[1]  = mk(1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    // requester 0, three beats
    vecs[2]  = mk(1'b1, 4'h1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    vecs[3]  = mk(1'b1, 4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1);
    vecs[4]  = mk(1'b1, 4'h1, 4'h0, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1);
    vecs[5]  = mk(1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1);
    // all request, single-beat packets: 1,2,3,0 with bubbles
    vecs[6]  = mk(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    vecs[7]  = mk(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h2, 1'b1, 8'h22, 2'd1, 1'b1);
    vecs[8]  = mk(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd1, 1'b0);
    vecs[9]  = mk(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h4, 1'b1, 8'h33, 2'd2, 1'b1);
    vecs[10] = mk(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0);
    vecs[11] = mk(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h8, 1'b1, 8'h44, 2'd3, 1'b1);
    vecs[12] = mk(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd3, 1'b0);
    vecs[13] = mk(1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1);
    // owner 2, req drops for two cycles while req[0] waits
    vecs[14] = mk(1'b1, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    vecs[15] = mk(1'b1, 4'h4, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    vecs[16] = mk(1'b1, 4'h4, 4'h0, 1'b1, 1'b1, 4'h4, 1'b1, 8'h33, 2'd2, 1'b1);
    vecs[17] = mk(1'b1, 4'h1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd2, 1'b1);
    vecs[18] = mk(1'b1, 4'h1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd2, 1'b1);
    vecs[19] = mk(1'b1, 4'h5, 4'h4, 1'b1, 1'b1, 4'h4, 1'b1, 8'h33, 2'd2, 1'b1);
    // owner 0 with o_ready low for three cycles
    vecs[20] = mk(1'b1, 4'h1, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd2, 1'b0);
    vecs[21] = mk(1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 8'h11, 2'd0, 1'b1);
    vecs[22] = mk(1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 8'h11, 2'd0, 1'b1);
    vecs[23] = mk(1'b1, 4'h1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, 8'h11, 2'd0, 1'b1);
    vecs[24] = mk(1'b1, 4'h1, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1);
    // owner 3 reset mid-packet; afterwards ptr must be 0 (1001 -> winner 0)
    vecs[25] = mk(1'b1, 4'h8, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    vecs[26] = mk(1'b1, 4'h8, 4'h0, 1'b1, 1'b1, 4'h8, 1'b1, 8'h44, 2'd3, 1'b1);
    vecs[27] = mk(1'b0, 4'h8, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd3, 1'b1);
    vecs[28] = mk(1'b1, 4'h9, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0);
    vecs[29] = mk(1'b1, 4'h9, 4'h1, 1'b1, 1'b1, 4'h1, 1'b1, 8'h11, 2'd0, 1'b1);

    data    = {8'h44, 8'h33, 8'h22, 8'h11};
    rst_n   = 1'b0; req = '0; last = '0; o_ready = 1'b1;
    data3   = {8'hC2, 8'hC1, 8'hC0};
    rst3_n  = 1'b0; req3 = '0; last3 = '0; o_ready3 = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      rst_n   = vecs[i].rst_n;
      req     = vecs[i].req;
      last    = vecs[i].last;
      o_ready = vecs[i].rdy;
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("row%0d gnt", i),     32'(gnt),     32'(vecs[i].gnt));
        check($sformatf("row%0d o_valid", i), 32'(o_valid), 32'(vecs[i].vld));
        check($sformatf("row%0d o_data", i),  32'(o_data),  32'(vecs[i].dat));
        check($sformatf("row%0d sel", i),     32'(sel),     32'(vecs[i].sel));
        check($sformatf("row%0d busy", i),    32'(busy),    32'(vecs[i].busy));
      end
    end

    // N=3: owner 2 finishes, pointer wraps to 0, then 3'b110 picks 1.
    @(posedge clk); #1;
    rst3_n = 1'b1; req3 = 3'b100; last3 = 3'b100;
    @(negedge clk);
    check("n3 idle gnt",  32'(gnt3),  32'h0);
    check("n3 idle busy", 32'(busy3), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("n3 own2 gnt",  32'(gnt3),    32'h4);
    check("n3 own2 sel",  32'(sel3),    32'h2);
    check("n3 own2 data", 32'(o_data3), 32'hC2);
    @(posedge clk); #1;
    req3 = 3'b110; last3 = 3'b010;
    @(negedge clk);
    check("n3 bubble busy", 32'(busy3), 32'h0);
    check("n3 bubble sel",  32'(sel3),  32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    check("n3 wrap gnt",  32'(gnt3),    32'h2);
    check("n3 wrap sel",  32'(sel3),    32'h1);
    check("n3 wrap data", 32'(o_data3), 32'hC1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rr_mux_arbiter
`default_nettype wire
